// File: rtl/pattern_recognizer.sv
// rtl/pattern_recognizer.sv - serial bit-pattern recognizer with loadable pattern and saturating match counter
module pattern_recognizer #(
  parameter int             N         = 4,
  parameter int             CNT_W     = 8,
  parameter logic [N-1:0]   RESET_PAT = 4'b1011
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             x,
  input  logic             valid,
  input  logic [N-1:0]     pattern,
  input  logic             load,
  input  logic             overlap,
  output logic             z,
  output logic [CNT_W-1:0] count
);

  // fill counts accepted history bits up to N-1, so it never needs more than clog2(N) bits
  localparam int            FW        = $clog2(N);
  localparam logic [FW-1:0] FILL_FULL = FW'(N - 1);

  logic [N-1:0]     r_pat;
  logic [N-2:0]     r_hist;
  logic [FW-1:0]    r_fill;
  logic             r_z;
  logic [CNT_W-1:0] r_count;

  logic [N-1:0]     w_window;
  logic             w_match;
  logic             w_cnt_sat;

  // candidate window is the stored history with the incoming bit appended as the newest
  always_comb begin
    w_window  = {r_hist, x};
    w_match   = (r_fill == FILL_FULL) && (w_window == r_pat);
    w_cnt_sat = &r_count;
  end

  // load has priority over accept; idle cycles only drop the match pulse
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_pat   <= RESET_PAT;
      r_hist  <= '0;
      r_fill  <= '0;
      r_z     <= 1'b0;
      r_count <= '0;
    end else if (load) begin
      r_pat   <= pattern;
      r_hist  <= '0;
      r_fill  <= '0;
      r_z     <= 1'b0;
      r_count <= '0;
    end else if (valid) begin
      r_hist <= w_window[N-2:0];
      if (w_match) begin
        r_z <= 1'b1;
        if (!w_cnt_sat) begin
          r_count <= r_count + 1'b1;
        end
        // non-overlapping mode discards the matched bits as a prefix for the next match
        r_fill <= overlap ? FILL_FULL : '0;
      end else begin
        r_z <= 1'b0;
        if (r_fill != FILL_FULL) begin
          r_fill <= r_fill + 1'b1;
        end
      end
    end else begin
      r_z <= 1'b0;
    end
  end

  assign z     = r_z;
  assign count = r_count;

endmodule

// File: doc/pattern_recognizer.md
# pattern_recognizer

Parametrised serial bit-pattern recognizer, the next generation of the fixed-sequence `recognizer` FSM. It samples a serial input `x` on qualified clock edges and compares the last N accepted bits against a run-time-loadable N-bit pattern. On each match it pulses a registered `z` for one cycle and increments a saturating match counter. It supports overlapping and non-overlapping detection modes and sits directly on a serial data stream in the same position as `recognizer`.

## Interface
- `N`, default 4: pattern length in bits; legal range 2..16.
- `CNT_W`, default 8: match-counter width; legal range 1..32.
- `RESET_PAT`, default 4'b1011 (N bits): pattern held after reset.
- `clk` input, 1: single clock; all state updates on its rising edge.
- `reset` input, 1: asynchronous, active-low reset (0 = in reset).
- `x` input, 1: serial data bit.
- `valid` input, 1: `x` is accepted only on edges where `valid`=1.
- `pattern` input, N: new pattern; `pattern[N-1]` is the first-received bit and `pattern[0]` the last.
- `load` input, 1: on an edge with `load`=1, latch `pattern` and restart detection.
- `overlap` input, 1: 1 = overlapping detection, 0 = non-overlapping.
- `z` output, 1: registered one-cycle match pulse.
- `count` output, CNT_W: number of matches, saturating.

## Operation
- Internal state:
  - `pat_r` [N]: the latched pattern.
  - `hist` [N-1]: the last N-1 accepted bits, newest in bit 0.
  - `fill` [0..N-1]: the number of valid history bits.
- Reset (`reset`=0, asynchronous, takes effect immediately without a clock edge):
  - `pat_r`=RESET_PAT, `hist`=0, `fill`=0.
  - Outputs: `z`=0, `count`=0.
- Priority on each rising edge: `load` first, then `valid`, then idle.
- Load (`load`=1):
  - `pat_r`←`pattern`, `hist`←0, `fill`←0, `count`←0, `z`←0.
  - `x` and `valid` are ignored in that cycle.
- Accept (`load`=0, `valid`=1):
  - Candidate window w = {`hist`, `x`}.
  - Match ⇔ `fill`==N-1 and w==`pat_r`.
  - `hist`←w[N-2:0].
  - On match:
    - `z`←1.
    - `count`←`count`+1 unless `count`==2^CNT_W-1, in which case it holds.
    - `fill`←N-1 if `overlap`=1, else `fill`←0 (fresh window required).
  - No match: `z`←0; `fill`←min(`fill`+1, N-1).
- Idle (`load`=0, `valid`=0):
  - `z`←0; `hist`, `fill`, `count` hold; `x` is don't-care.
- `overlap` is sampled on the matching edge only; changing it between matches is legal.
- After saturation, `z` still pulses on every match; only `count` stops.

## Timing
- Latency: the match decision uses `x` at edge k; `z` is high during cycle k→k+1 and `count` reflects that match from the same edge.
- `z` width is exactly one cycle per match. Back-to-back matches (overlap mode, e.g. N=2, pattern 11, stream of 1s) keep `z` high on consecutive cycles.
- The first possible match is on the N-th accepted bit after reset or load.
- Gaps in `valid` stretch the window but never break it; the N bits need not be contiguous in time.
- Reset asserted mid-match or mid-load: all state clears asynchronously. Deassertion takes effect at the next edge, and no `z` pulse is produced from pre-reset history.

## Test plan
- Defaults (N=4, pattern 1011, `overlap`=1, `valid`=1). Release reset, then stream 0,0,1,0,1,1,0,1,0,1,1,0,1,1,0,1 → `z` pulses after bits 6, 11 and 14; final `count`=3. Same stream with `overlap`=0 → pulses after bits 6 and 11 only; `count`=2.
- Load `pattern`=1010 with `load`=1 while `x`=1 → `count`=0. Then stream 1,0,1,0,1,0: with `overlap`=1, pulses after bits 4 and 6 and `count`=2; with `overlap`=0, pulse after bit 4 only and `count`=1.
- Pattern 1011, feed 1,0,1, then hold `valid`=0 for 3 cycles with `x` toggling, then feed 1 with `valid`=1 → exactly one `z` pulse, one cycle after that edge; `count`=1.
- Feed 1,0,1, then `load` the same pattern 1011, then feed 1 → no pulse. The following 1,0,1,1 → one pulse.
- CNT_W=2, pattern 1011, overlap mode, stream 1,0,1,1 five times → five `z` pulses; `count` reads 1,2,3,3,3.
- Drive `reset`=0 mid-cycle after 1,0,1 → `z`=0 and `count`=0 before the next edge. After release, a single 1 → no pulse, and `pat_r` equals RESET_PAT.
